// File: rtl/queue_pkg.sv
// Shared constants for the queue consumer: data width, CPU load address map,
// STATUS bit positions and the fetch FSM encoding.
package queue_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_COUNT  = 2'd2,
    ADDR_CLRERR = 2'd3
  } cpu_addr_e;

  localparam int ST_Q_EMPTY   = 0;
  localparam int ST_BUF_EMPTY = 1;
  localparam int ST_BUF_FULL  = 2;
  localparam int ST_BUSY      = 3;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_CAPTURE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/queue_reader_if.sv
// CPU data-memory load port of the queue reader; the CPU is the master.
interface queue_reader_if;
  import queue_pkg::*;

  logic              req;
  logic [1:0]        addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              stall;

  modport master (output req, addr, input ack, rdata, stall);
  modport slave  (input req, addr, output ack, rdata, stall);
endinterface

// File: rtl/queue_prefetch_buf.sv
// Small power-of-2 FIFO holding prefetched queue words; a write and a read in
// the same cycle leave the count unchanged and keep order.
module queue_prefetch_buf #(
  parameter  int DEPTH = 2,
  parameter  int W     = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_s, rd_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign rd_s      = rd_en_i && !empty_o;
  assign wr_s      = wr_en_i && (!full_o || rd_s);

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/queue_reader.sv
// Consumer end of the push/pop queue: prefetches words with single outstanding
// pops and serves CPU loads of DATA/STATUS/COUNT/CLRERR with registered responses.
module queue_reader
  import queue_pkg::*;
#(
  parameter int PF_DEPTH = 2,
  parameter int READ_LAT = 1,
  parameter bit BLOCKING = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_empty_i,
  output logic              q_pop_o,
  input  logic [DATA_W-1:0] q_rdata_i,
  queue_reader_if.slave     cpu_bus,
  output logic              underflow_err_o,
  output logic [CNT_W-1:0]  words_read_o
);

  localparam int CNT_BW = $clog2(PF_DEPTH + 1);
  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  fetch_state_e      state_q;
  logic [LAT_W-1:0]  lat_q;
  logic              pop_q;
  logic [CNT_BW-1:0] buf_count_s;
  logic              buf_full_s, buf_empty_s, buf_wr_s, buf_rd_s;
  logic [DATA_W-1:0] buf_head_s, status_s;
  logic              pend_q, pend_d, ack_q, ack_d, stall_q, stall_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept_s;

  queue_prefetch_buf #(.DEPTH(PF_DEPTH), .W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (buf_wr_s),
    .wr_data_i (q_rdata_i),
    .rd_en_i   (buf_rd_s),
    .rd_data_o (buf_head_s),
    .count_o   (buf_count_s),
    .full_o    (buf_full_s),
    .empty_o   (buf_empty_s)
  );

  assign buf_wr_s = (state_q == FS_CAPTURE);

  // Fetch FSM: one pop in flight at most, captured READ_LAT cycles after the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      lat_q   <= '0;
      pop_q   <= 1'b0;
    end else begin
      pop_q <= 1'b0;
      case (state_q)
        FS_IDLE: begin
          if (!q_empty_i && (buf_count_s < CNT_BW'(PF_DEPTH))) begin
            pop_q   <= 1'b1;
            lat_q   <= '0;
            state_q <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (lat_q == LAT_W'(READ_LAT - 1)) begin
            state_q <= FS_CAPTURE;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        FS_CAPTURE: state_q <= FS_IDLE;
        default:    state_q <= FS_IDLE;
      endcase
    end
  end

  always_comb begin
    status_s               = '0;
    status_s[ST_Q_EMPTY]   = q_empty_i;
    status_s[ST_BUF_EMPTY] = buf_empty_s;
    status_s[ST_BUF_FULL]  = buf_full_s;
    status_s[ST_BUSY]      = (state_q != FS_IDLE);
  end

  assign accept_s = cpu_bus.req && !stall_q && !ack_q;

  // A stalled DATA load is served from the buffer head as soon as a word lands there.
  always_comb begin
    pend_d   = pend_q;
    stall_d  = stall_q;
    ack_d    = 1'b0;
    rdata_d  = '0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    buf_rd_s = 1'b0;
    if (pend_q) begin
      if (!buf_empty_s) begin
        ack_d    = 1'b1;
        rdata_d  = buf_head_s;
        buf_rd_s = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        pend_d   = 1'b0;
        stall_d  = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (accept_s) begin
      case (cpu_addr_e'(cpu_bus.addr))
        ADDR_DATA: begin
          if (!buf_empty_s) begin
            ack_d    = 1'b1;
            rdata_d  = buf_head_s;
            buf_rd_s = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end else if ((state_q != FS_IDLE) || !q_empty_i || BLOCKING) begin
            pend_d  = 1'b1;
            stall_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
        ADDR_STATUS: begin
          ack_d   = 1'b1;
          rdata_d = status_s;
        end
        ADDR_COUNT: begin
          ack_d   = 1'b1;
          rdata_d = DATA_W'(cnt_q);
        end
        ADDR_CLRERR: begin
          ack_d = 1'b1;
          err_d = 1'b0;
        end
        default: ack_d = 1'b0;
      endcase
    end else begin
      ack_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_pop_o         = pop_q;
  assign cpu_bus.ack     = ack_q;
  assign cpu_bus.rdata   = rdata_q;
  assign cpu_bus.stall   = stall_q;
  assign underflow_err_o = err_q;
  assign words_read_o    = cnt_q;

endmodule

// File: tb/tb_queue_reader.sv
// Directed and randomized bench for queue_reader: a queue model feeds the DUT and a
// word-order scoreboard checks every load response.
module tb_queue_reader;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_CLRERR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_empty = 1'b1;
  logic        nb_q_empty = 1'b1;
  logic [31:0] q_rdata = 32'h0;
  logic        q_pop, nb_pop, err, nb_err;
  logic [15:0] words, nb_words;

  int checks = 0;
  int errors = 0;

  logic [31:0] qmem[$];
  logic [31:0] exp_q[$];
  int          delivered, pend, lat, npop, deliv_req;
  logic [1:0]  paddr;
  logic        qe_req;
  logic [31:0] w;

  queue_reader_if cpu_if ();
  queue_reader_if nb_if ();

  always #5 clk = ~clk;

  queue_reader #(.PF_DEPTH(2), .READ_LAT(1), .BLOCKING(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .q_empty_i(q_empty), .q_pop_o(q_pop), .q_rdata_i(q_rdata),
    .cpu_bus(cpu_if), .underflow_err_o(err), .words_read_o(words)
  );

  queue_reader #(.PF_DEPTH(2), .READ_LAT(1), .BLOCKING(1'b0), .CNT_W(16)) dut_nb (
    .clk(clk), .rst(rst), .q_empty_i(nb_q_empty), .q_pop_o(nb_pop), .q_rdata_i(q_rdata),
    .cpu_bus(nb_if), .underflow_err_o(nb_err), .words_read_o(nb_words)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the queue model answers a pop seen in the finished cycle.
  task automatic tick();
    logic popped;
    popped = q_pop;
    @(posedge clk);
    #1;
    if (popped === 1'b1 && qmem.size() > 0) q_rdata = qmem.pop_front();
    q_empty = (qmem.size() == 0);
  endtask

  task automatic push(input logic [31:0] d);
    qmem.push_back(d);
    q_empty = 1'b0;
  endtask

  task automatic issue(input logic [1:0] a);
    cpu_if.req  = 1'b1;
    cpu_if.addr = a;
    tick();
    cpu_if.req  = 1'b0;
  endtask

  task automatic nb_issue(input logic [1:0] a);
    nb_if.req  = 1'b1;
    nb_if.addr = a;
    tick();
    nb_if.req  = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int limit);
    int n;
    n = 0;
    while (cpu_if.ack !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_ack"}, cpu_if.ack, 1'b1);
  endtask

  task automatic read_data(input string tag, input logic [31:0] exp);
    issue(A_DATA);
    wait_ack(tag, 20);
    chk({tag, "_rdata"}, cpu_if.rdata, exp);
    tick();
  endtask

  task automatic rnd_observe();
    lat++;
    if (cpu_if.ack === 1'b1) begin
      if (paddr == A_DATA) begin
        if (exp_q.size() > 0) begin
          chk("rnd_data", cpu_if.rdata, exp_q.pop_front());
          delivered++;
        end else begin
          chk("rnd_data_spurious", cpu_if.ack, 1'b0);
        end
      end else if (paddr == A_STATUS) begin
        chk("rnd_st_lat", lat, 1);
        chk("rnd_st_qempty", cpu_if.rdata[0], qe_req);
        chk("rnd_st_hi", cpu_if.rdata[31:4], 28'h0);
        chk("rnd_st_fullempty", cpu_if.rdata[2] & cpu_if.rdata[1], 1'b0);
      end else begin
        chk("rnd_cnt_lat", lat, 1);
        chk("rnd_cnt", cpu_if.rdata, deliv_req);
      end
      pend = 0;
    end else if (paddr != A_DATA) begin
      chk("rnd_lat1", cpu_if.ack, 1'b1);
      pend = 0;
    end else begin
      chk("rnd_stall", cpu_if.stall, 1'b1);
      if (lat > 300) begin
        chk("rnd_timeout", cpu_if.ack, 1'b1);
        pend = 0;
      end
    end
  endtask

  initial begin
    cpu_if.req = 1'b0; cpu_if.addr = 2'd0;
    nb_if.req  = 1'b0; nb_if.addr  = 2'd0;

    // Reset state
    tick(); tick();
    chk("rst_pop", q_pop, 1'b0);
    chk("rst_ack", cpu_if.ack, 1'b0);
    chk("rst_stall", cpu_if.stall, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_words", words, 16'h0);
    chk("rst_nb_err", nb_err, 1'b0);
    rst = 1'b0;
    tick();

    // 1: prefetch pops, spaced pop/wait/capture, stop at two buffered words
    push(32'hA5A5_0001); push(32'hA5A5_0002); push(32'hA5A5_0003);
    npop = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (q_pop === 1'b1) npop++;
      chk("t1_pop", q_pop, (i == 1 || i == 4));
    end
    chk("t1_npop", npop, 2);
    issue(A_STATUS);
    chk("t1_st_ack", cpu_if.ack, 1'b1);
    chk("t1_status", cpu_if.rdata, 32'h4);
    tick();
    chk("t1_ack_drop", cpu_if.ack, 1'b0);

    // 2: back-to-back DATA loads from the buffer
    issue(A_DATA);
    chk("t2_ack1", cpu_if.ack, 1'b1);
    chk("t2_rd1", cpu_if.rdata, 32'hA5A5_0001);
    chk("t2_w1", words, 16'd1);
    tick();
    issue(A_DATA);
    chk("t2_ack2", cpu_if.ack, 1'b1);
    chk("t2_rd2", cpu_if.rdata, 32'hA5A5_0002);
    chk("t2_w2", words, 16'd2);
    tick();
    read_data("t2_rd3", 32'hA5A5_0003);
    tick(); tick();

    // 3: blocking load on an empty system stalls until a word arrives
    issue(A_DATA);
    chk("t3_stall", cpu_if.stall, 1'b1);
    chk("t3_noack", cpu_if.ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_hold", cpu_if.stall, 1'b1);
    end
    push(32'h0000_BEEF);
    for (int i = 0; i < 10 && q_pop !== 1'b1; i++) tick();
    chk("t3_pop_seen", q_pop, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t3_ack_timing", cpu_if.ack, (k == 3));
      chk("t3_stall_timing", cpu_if.stall, (k != 3));
    end
    chk("t3_rdata", cpu_if.rdata, 32'h0000_BEEF);
    tick();
    chk("t3_words", words, 16'd4);

    // 4: non-blocking underflow and error clear
    nb_issue(A_DATA);
    chk("t4_ack", nb_if.ack, 1'b1);
    chk("t4_rdata", nb_if.rdata, 32'h0);
    chk("t4_err", nb_err, 1'b1);
    chk("t4_words", nb_words, 16'h0);
    tick();
    chk("t4_err_sticky", nb_err, 1'b1);
    nb_issue(A_STATUS);
    chk("t4_status", nb_if.rdata, 32'h3);
    tick();
    nb_issue(A_CLRERR);
    chk("t4_clr_ack", nb_if.ack, 1'b1);
    chk("t4_clr_rdata", nb_if.rdata, 32'h0);
    chk("t4_clr_err", nb_err, 1'b0);
    tick();

    // 5: capture coincides with a head pop
    push(32'h11); push(32'h22); push(32'h33);
    repeat (10) tick();
    issue(A_DATA);
    chk("t5_rd1", cpu_if.rdata, 32'h11);
    tick();
    chk("t5_pop", q_pop, 1'b1);
    tick();
    issue(A_DATA);
    chk("t5_ack2", cpu_if.ack, 1'b1);
    chk("t5_rd2", cpu_if.rdata, 32'h22);
    tick();
    issue(A_STATUS);
    chk("t5_status", cpu_if.rdata, 32'h1);
    tick();
    read_data("t5_rd3", 32'h33);
    chk("t5_words", words, 16'd7);
    tick(); tick();

    // 6: reset while a stalled load waits on an in-flight pop
    issue(A_DATA);
    chk("t6_stall", cpu_if.stall, 1'b1);
    push(32'h0000_DEAD);
    for (int i = 0; i < 10 && q_pop !== 1'b1; i++) tick();
    chk("t6_pop_seen", q_pop, 1'b1);
    #3 rst = 1'b1;
    qmem.delete();
    q_empty = 1'b1;
    q_rdata = 32'h0;
    #1;
    chk("t6_async_stall", cpu_if.stall, 1'b0);
    chk("t6_async_ack", cpu_if.ack, 1'b0);
    chk("t6_async_pop", q_pop, 1'b0);
    chk("t6_async_words", words, 16'h0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    issue(A_STATUS);
    chk("t6_status", cpu_if.rdata, 32'h3);
    tick();

    // Randomized traffic against the word-order scoreboard
    delivered = 0;
    pend = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c >= 400 && pend == 0 && exp_q.size() == 0) break;
      if (qmem.size() < 32 && ((c < 400 && $urandom_range(3) == 0) ||
                               (pend != 0 && paddr == A_DATA && exp_q.size() == 0))) begin
        w = $urandom;
        push(w);
        exp_q.push_back(w);
      end
      if (pend == 0 && cpu_if.stall === 1'b0 && cpu_if.ack === 1'b0 &&
          (c >= 400 || $urandom_range(1) == 0)) begin
        paddr       = (c >= 400) ? A_DATA : 2'($urandom_range(2));
        cpu_if.req  = 1'b1;
        cpu_if.addr = paddr;
        qe_req      = q_empty;
        deliv_req   = delivered;
        pend        = 1;
        lat         = 0;
      end
      tick();
      cpu_if.req = 1'b0;
      if (pend != 0) rnd_observe();
    end
    chk("rnd_drained", exp_q.size(), 0);
    tick();
    chk("rnd_words", words, 16'(delivered));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
